lif_array: RTL and testbench
============================

LIF_ARRAY -- requirements
Module: lif_array

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning the number of independent neuron channels.
REQ-002 SHALL have parameter W, default 8, meaning the membrane, current and threshold width in bits.
REQ-003 SHALL have parameter TW, default 4, meaning the refractory timer width in bits.
REQ-004 SHALL have port clk, input, 1 bit: the clock.
REQ-005 SHALL have port rst_n, input, 1 bit: the reset, which is synchronous and active-low.
REQ-006 SHALL have port en, input, 1 bit: a timestep strobe; all channels advance one step on each clk edge where en=1.
REQ-007 SHALL have port current, input, N_CH*W bits: the per-channel input current; channel k occupies bits [k*W +: W].
REQ-008 SHALL have port cfg_we, input, 1 bit: the configuration write strobe.
REQ-009 SHALL have port cfg_threshold, input, W bits: the new base threshold.
REQ-010 SHALL have port cfg_leak, input, 3 bits: the new leak shift.
REQ-011 SHALL have port cfg_refrac, input, TW bits: the new refractory period in steps.
REQ-012 SHALL have port spike, output, N_CH bits: registered per-channel spike flags.
REQ-013 SHALL have port state, output, N_CH*W bits: registered per-channel membrane potentials, packed the same way as current.

Function
REQ-014 SHALL compute, per channel and per step with timer==0: v_next = sat(current + (state >> leak)), where the sum is formed at W+1 bits and saturated to 2^W-1.
REQ-015 SHALL treat leak=0 as a perfect integrator with no leak.
REQ-016 SHALL, when v_next >= thr_eff and timer==0: set spike=1, set state=0, and load timer with refrac, all on the same edge.
REQ-017 SHALL, when v_next < thr_eff and timer==0: set state=v_next and spike=0.
REQ-018 SHALL, when timer>0 on an en step: decrement timer, hold state at 0, ignore current, and set spike=0.
REQ-019 SHALL, with refrac=0, allow a spike on every consecutive step.
REQ-020 SHALL, on cycles with en=0: hold state and timer unchanged and drive spike=0.
REQ-021 SHALL assert spike for exactly one clk cycle per firing, with one-cycle latency from the sampling en edge.
REQ-022 SHALL capture cfg_threshold, cfg_leak and cfg_refrac into shared configuration registers on an edge with cfg_we=1.
REQ-023 SHALL, when cfg_we and en coincide, evaluate that step with the old configuration; the new values apply from the next step.
REQ-024 SHALL make a new refrac value affect only timers loaded after the write; running timers continue uninterrupted.
REQ-025 SHALL keep channels fully independent; only the configuration is shared.

Reset
REQ-026 SHALL, on rst_n=0 at a clk edge, set every state=0, timer=0 and spike=0, regardless of en or cfg_we, including mid-refractory.
REQ-027 SHALL reset configuration to threshold=2^(W-1)-1 (127 for W=8), leak=1 and refrac=2^TW-1 (15 for TW=4).

Configuration
REQ-028 SHALL, with LIF_ADAPT_THRESH_EN defined, keep a per-channel W-bit offset register.
REQ-029 SHALL, with LIF_ADAPT_THRESH_EN defined, set thr_eff = sat(threshold + offset).
REQ-030 SHALL, with LIF_ADAPT_THRESH_EN defined, update offset as follows: +1 (saturating) on a spike step; -1 (floor 0) on any other en step; reset value 0.
REQ-031 SHALL, without LIF_ADAPT_THRESH_EN, set thr_eff = threshold and contain no offset logic.

Structure
REQ-032 SHALL place reset constants (default threshold, leak and refrac expressions) and the leak-shift width in shared package lif_pkg.
REQ-033 SHALL implement one channel in sub-module lif_core (state, timer and optional offset), instantiated N_CH times via generate; configuration registers live in lif_array.

Verification
REQ-034 SHALL cover: reset, then current=0 for 10 steps -> state=0 and spike=0 on all channels.
REQ-035 SHALL cover: defaults with ch0 current=64 -> state 64, 96, 112, 120, 124, 126; spike on step 7 with state=0; then 15 steps with state=0 and no spike; integration resumes on step 23.
REQ-036 SHALL cover: leak=0, threshold=255, current=100 -> state 100, 200, then saturates at 255 and spikes on step 3.
REQ-037 SHALL cover: refrac=0, threshold=10, current=20 -> spike=1 on every step, and spike=0 on cycles with en=0 between steps.
REQ-038 SHALL cover: a cfg_we threshold write of 127->50 coinciding with an en step where v_next=60 -> no spike that step; the next step with v_next>=50 spikes.
REQ-039 SHALL cover: rst_n=0 pulsed mid-refractory -> timer=0 and state=0; the next step integrates immediately; with LIF_ADAPT_THRESH_EN, 3 rapid spikes -> offset=3 and thr_eff=threshold+3.

Source files
------------

// File: rtl/lif_pkg.sv
// lif_pkg: constants shared by the LIF neuron array.
// These are the configuration reset values and the width of the leak shift.
package lif_pkg;

  // Width of the leak shift amount (cfg_leak).
  localparam int LEAK_W = 3;

  // Leak shift loaded at reset: state decays by half each step.
  localparam logic [LEAK_W-1:0] LEAK_RST = 3'd1;

  // Default base threshold: mid-scale, 2^(w-1)-1.
  function automatic int def_threshold(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Default refractory period: the longest the timer can hold, 2^(tw)-1.
  function automatic int def_refrac(input int tw);
    return (1 << tw) - 1;
  endfunction

endpackage

// File: rtl/lif_core.sv
// lif_core: one leaky integrate-and-fire channel.
// It holds the membrane state, the refractory timer and the spike flag.
// Optional adaptive threshold (LIF_ADAPT_THRESH_EN): each channel keeps an
// offset that rises on every spike, decays on other steps, and is added to
// the shared base threshold.
module lif_core
  import lif_pkg::*;
#(
  parameter int W  = 8,
  parameter int TW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [W-1:0]      current,
  input  logic [W-1:0]      thr,
  input  logic [LEAK_W-1:0] leak,
  input  logic [TW-1:0]     refrac,
  output logic              spike,
  output logic [W-1:0]      state
);

  logic [W-1:0]  state_d, state_q;
  logic [TW-1:0] timer_d, timer_q;
  logic          spike_d, spike_q;
  logic [W:0]    sum;
  logic [W-1:0]  v_next;
  logic [W-1:0]  thr_eff;
  logic          fire;

  // Candidate potential: current plus leaked state, formed one bit wider and clamped to full scale.
  always_comb begin
    sum    = {1'b0, current} + {1'b0, state_q >> leak};
    v_next = sum[W] ? '1 : sum[W-1:0];
  end

`ifdef LIF_ADAPT_THRESH_EN
  logic [W-1:0] offset_d, offset_q;
  logic [W:0]   thr_sum;

  // Effective threshold is the base plus this channel's offset, clamped to full scale.
  always_comb begin
    thr_sum = {1'b0, thr} + {1'b0, offset_q};
    thr_eff = thr_sum[W] ? '1 : thr_sum[W-1:0];
  end

  // Offset rises on a firing step and falls toward zero on every other en step.
  always_comb begin
    offset_d = offset_q;
    if (en) begin
      if (fire) begin
        if (offset_q != '1) offset_d = offset_q + 1'b1;
      end else if (offset_q != '0) begin
        offset_d = offset_q - 1'b1;
      end
    end
  end

  // Offset register.
  always_ff @(posedge clk) begin
    if (!rst_n) offset_q <= '0;
    else        offset_q <= offset_d;
  end
`else
  assign thr_eff = thr;
`endif

  // A channel fires only on an en step outside refractory.
  assign fire = en && (timer_q == '0) && (v_next >= thr_eff);

  // Step update: refractory countdown, fire-and-reset, or plain integration.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    spike_d = 1'b0;
    if (en) begin
      if (timer_q != '0) begin
        timer_d = timer_q - 1'b1;
        state_d = '0;
      end else if (fire) begin
        spike_d = 1'b1;
        state_d = '0;
        timer_d = refrac;
      end else begin
        state_d = v_next;
      end
    end
  end

  // Channel registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= '0;
      timer_q <= '0;
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      spike_q <= spike_d;
    end
  end

  assign spike = spike_q;
  assign state = state_q;

endmodule

// File: rtl/lif_array.sv
// lif_array: N_CH independent LIF channels that share one configuration.
// Configuration is registered here, so a write that lands on an en step
// takes effect on the following step.
// Optional feature macro: LIF_ADAPT_THRESH_EN (per-channel adaptive threshold).
module lif_array
  import lif_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 8,
  parameter int TW   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [N_CH*W-1:0]   current,
  input  logic                cfg_we,
  input  logic [W-1:0]        cfg_threshold,
  input  logic [LEAK_W-1:0]   cfg_leak,
  input  logic [TW-1:0]       cfg_refrac,
  output logic [N_CH-1:0]     spike,
  output logic [N_CH*W-1:0]   state
);

  localparam logic [W-1:0]  THR_RST = W'(def_threshold(W));
  localparam logic [TW-1:0] REF_RST = TW'(def_refrac(TW));

  logic [W-1:0]      thr_d, thr_q;
  logic [LEAK_W-1:0] leak_d, leak_q;
  logic [TW-1:0]     refrac_d, refrac_q;

  // Load new configuration on a write strobe; otherwise hold it.
  always_comb begin
    thr_d    = thr_q;
    leak_d   = leak_q;
    refrac_d = refrac_q;
    if (cfg_we) begin
      thr_d    = cfg_threshold;
      leak_d   = cfg_leak;
      refrac_d = cfg_refrac;
    end
  end

  // Shared configuration registers. Reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      thr_q    <= THR_RST;
      leak_q   <= LEAK_RST;
      refrac_q <= REF_RST;
    end else begin
      thr_q    <= thr_d;
      leak_q   <= leak_d;
      refrac_q <= refrac_d;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    lif_core #(.W(W), .TW(TW)) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .current (current[k*W +: W]),
      .thr     (thr_q),
      .leak    (leak_q),
      .refrac  (refrac_q),
      .spike   (spike[k]),
      .state   (state[k*W +: W])
    );
  end

endmodule

// File: tb/tb_lif_array.sv
// Testbench for lif_array: directed scenarios plus a randomized run.
// All of it is checked against a step-level behavioural model.
module tb_lif_array;
  localparam int N_CH = 4;
  localparam int W    = 8;
  localparam int TW   = 4;
  localparam int VMAX = (1 << W) - 1;

  logic              clk = 1'b0;
  logic              rst_n, en, cfg_we;
  logic [N_CH*W-1:0] current;
  logic [W-1:0]      cfg_threshold;
  logic [2:0]        cfg_leak;
  logic [TW-1:0]     cfg_refrac;
  logic [N_CH-1:0]   spike;
  logic [N_CH*W-1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: membrane, refractory steps left, offset, spike; plus shared config.
  int m_v[N_CH], m_t[N_CH], m_off[N_CH], m_spk[N_CH];
  int m_thr, m_leak, m_ref;

  lif_array #(.N_CH(N_CH), .W(W), .TW(TW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .current       (current),
    .cfg_we        (cfg_we),
    .cfg_threshold (cfg_threshold),
    .cfg_leak      (cfg_leak),
    .cfg_refrac    (cfg_refrac),
    .spike         (spike),
    .state         (state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One timestep of the neuron model, as observed at a clock edge.
  task automatic model_edge();
    int cur, vn, te;
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) begin
        m_v[k] = 0; m_t[k] = 0; m_off[k] = 0; m_spk[k] = 0;
      end
      m_thr  = (1 << (W - 1)) - 1;
      m_leak = 1;
      m_ref  = (1 << TW) - 1;
      return;
    end
    for (int k = 0; k < N_CH; k++) begin
      m_spk[k] = 0;
      if (!en) continue;
      if (m_t[k] > 0) begin
        m_t[k]   = m_t[k] - 1;
        m_v[k]   = 0;
        m_off[k] = (m_off[k] > 0) ? m_off[k] - 1 : 0;
      end else begin
        cur = int'(current[k*W +: W]);
        vn  = cur + (m_v[k] >> m_leak);
        if (vn > VMAX) vn = VMAX;
`ifdef LIF_ADAPT_THRESH_EN
        te = m_thr + m_off[k];
        if (te > VMAX) te = VMAX;
`else
        te = m_thr;
`endif
        if (vn >= te) begin
          m_spk[k] = 1;
          m_v[k]   = 0;
          m_t[k]   = m_ref;
          m_off[k] = (m_off[k] < VMAX) ? m_off[k] + 1 : VMAX;
        end else begin
          m_v[k]   = vn;
          m_off[k] = (m_off[k] > 0) ? m_off[k] - 1 : 0;
        end
      end
    end
    if (cfg_we) begin
      m_thr  = int'(cfg_threshold);
      m_leak = int'(cfg_leak);
      m_ref  = int'(cfg_refrac);
    end
  endtask

  function automatic logic [N_CH*W-1:0] exp_state();
    logic [N_CH*W-1:0] r;
    for (int k = 0; k < N_CH; k++) r[k*W +: W] = W'(m_v[k]);
    return r;
  endfunction

  function automatic logic [N_CH-1:0] exp_spike();
    logic [N_CH-1:0] r;
    for (int k = 0; k < N_CH; k++) r[k] = (m_spk[k] != 0);
    return r;
  endfunction

  // Advance one clock; outputs settle 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; cfg_we = 1'b0; current = '0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic do_cfg(input int thr, input int leak, input int refr);
    en = 1'b0; cfg_we = 1'b1;
    cfg_threshold = W'(thr); cfg_leak = 3'(leak); cfg_refrac = TW'(refr);
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    cfg_threshold = '0; cfg_leak = '0; cfg_refrac = '0;
    do_reset();
    n_checks++;
    if (state !== '0 || spike !== '0) begin
      n_fail++;
      $display("FAIL reset_state: state=%h spike=%b, required 0/0", state, spike);
    end
    en = 1'b1; current = '0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_checks++;
      if (state !== '0 || spike !== '0 || state !== exp_state()) begin
        n_fail++;
        $display("FAIL zero_current step %0d: state=%h spike=%b, required 0/0", i + 1, state, spike);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_default_sequence();
    int exp_v[6] = '{64, 96, 112, 120, 124, 126};
    do_reset();
    current = '0; current[W-1:0] = W'(64); en = 1'b1;
    for (int s = 1; s <= 23; s++) begin
      int ev, es;
      cyc();
      if (s <= 6)      begin ev = exp_v[s-1]; es = 0; end
      else if (s == 7) begin ev = 0;          es = 1; end
      else if (s < 23) begin ev = 0;          es = 0; end
      else             begin ev = 64;         es = 0; end
      n_checks++;
      if (int'(state[W-1:0]) != ev || int'(spike[0]) != es ||
          state !== exp_state() || spike !== exp_spike()) begin
        n_fail++;
        $display("FAIL default_seq step %0d: state0=%0d spike0=%b, required %0d/%0d",
                 s, state[W-1:0], spike[0], ev, es);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    do_cfg(255, 0, 15);
    current = '0; current[W-1:0] = W'(100); en = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      int ev, es;
      cyc();
      ev = (s == 1) ? 100 : (s == 2) ? 200 : 0;
      es = (s == 3) ? 1 : 0;
      n_checks++;
      if (int'(state[W-1:0]) != ev || int'(spike[0]) != es || state !== exp_state()) begin
        n_fail++;
        $display("FAIL saturate step %0d: state0=%0d spike0=%b, required %0d/%0d",
                 s, state[W-1:0], spike[0], ev, es);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_refrac0();
    do_reset();
    do_cfg(10, 1, 0);
    for (int k = 0; k < N_CH; k++) current[k*W +: W] = W'(20);
    for (int i = 0; i < 12; i++) begin
      logic [N_CH-1:0] es;
      en = (i % 2 == 0);
      es = en ? '1 : '0;
      cyc();
      n_checks++;
      if (spike !== es || spike !== exp_spike() || state !== exp_state()) begin
        n_fail++;
        $display("FAIL refrac0 cycle %0d (en=%b): spike=%b, required %b", i, en, spike, es);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_cfg_coincide();
    do_reset();
    current = '0; current[W-1:0] = W'(60);
    en = 1'b1; cfg_we = 1'b1;
    cfg_threshold = W'(50); cfg_leak = 3'd1; cfg_refrac = TW'(15);
    cyc();
    cfg_we = 1'b0;
    n_checks++;
    if (spike[0] !== 1'b0 || state[W-1:0] !== W'(60)) begin
      n_fail++;
      $display("FAIL cfg_coincide write step: spike0=%b state0=%0d, required 0/60", spike[0], state[W-1:0]);
    end
    cyc();
    n_checks++;
    if (spike[0] !== 1'b1 || state[W-1:0] !== '0 || spike !== exp_spike()) begin
      n_fail++;
      $display("FAIL cfg_coincide next step: spike0=%b state0=%0d, required 1/0", spike[0], state[W-1:0]);
    end
    en = 1'b0;
  endtask

  task automatic test_reset_mid_refrac();
    do_reset();
    current = '0; current[W-1:0] = W'(64); en = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    // Reset asserted with en and a config write active; both must be ignored.
    rst_n = 1'b0; cfg_we = 1'b1; cfg_threshold = W'(5);
    cyc();
    rst_n = 1'b1; cfg_we = 1'b0;
    n_checks++;
    if (state !== '0 || spike !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_refrac: state=%h spike=%b, required 0/0", state, spike);
    end
    cyc();
    n_checks++;
    if (state[W-1:0] !== W'(64) || spike[0] !== 1'b0 || state !== exp_state()) begin
      n_fail++;
      $display("FAIL post_reset_integrate: state0=%0d spike0=%b, required 64/0", state[W-1:0], spike[0]);
    end
`ifdef LIF_ADAPT_THRESH_EN
    do_reset();
    do_cfg(10, 1, 0);
    current = '0; current[W-1:0] = W'(20); en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (spike[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL adapt_spike %0d: spike0=%b, required 1", i, spike[0]);
      end
    end
    // Offset is now 3, so threshold 13 must block a potential of 12.
    current[W-1:0] = W'(12);
    cyc();
    n_checks++;
    if (spike[0] !== 1'b0 || state[W-1:0] !== W'(12)) begin
      n_fail++;
      $display("FAIL adapt_thr_eff: spike0=%b state0=%0d, required 0/12", spike[0], state[W-1:0]);
    end
`endif
    en = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      rst_n  = ($urandom_range(0, 99) != 0);
      en     = ($urandom_range(0, 3) != 0);
      cfg_we = ($urandom_range(0, 19) == 0);
      cfg_threshold = W'($urandom_range(20, VMAX));
      cfg_leak      = 3'($urandom);
      cfg_refrac    = TW'($urandom_range(0, 3));
      for (int k = 0; k < N_CH; k++) current[k*W +: W] = W'($urandom_range(0, 80));
      cyc();
      n_checks++;
      if (state !== exp_state() || spike !== exp_spike()) begin
        n_fail++;
        $display("FAIL random cycle %0d: state=%h spike=%b, required state=%h spike=%b",
                 i, state, spike, exp_state(), exp_spike());
      end
    end
    rst_n = 1'b1; en = 1'b0; cfg_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; cfg_we = 1'b0; current = '0;
    cfg_threshold = '0; cfg_leak = '0; cfg_refrac = '0;
    test_reset();
    test_default_sequence();
    test_saturate();
    test_refrac0();
    test_cfg_coincide();
    test_reset_mid_refrac();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
